// File: rtl/sm_bus_pkg.sv
//==============================================================================
// Module   : sm_bus_pkg
// Brief    : Shared types and defaults for the sm_bus memory-mapped matrix.
// Revision : 1.0
//==============================================================================
`default_nettype none

package sm_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } busState_t;

   // Slave 3 is packed in the most significant word.
   localparam logic [4*32-1:0] DEF_BASE = {32'h0000_0900, 32'h0000_0800,
                                           32'h0000_0400, 32'h0000_0000};
   localparam logic [4*32-1:0] DEF_MASK = {32'h0000_0F00, 32'h0000_0F00,
                                           32'h0000_0FF0, 32'h0000_0C00};

   localparam int FLT_ADDR_OFS = 0;
   localparam int FLT_STAT_OFS = 4;

   localparam int STAT_UNMAPPED_BIT = 0;
   localparam int STAT_TIMEOUT_BIT  = 1;

endpackage

`default_nettype wire

// File: rtl/sm_bus_decoder.sv
//==============================================================================
// Module   : sm_bus_decoder
// Brief    : Combinational base/mask address decoder with fault-window priority.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sm_bus_decoder
   import sm_bus_pkg::*;
#(
   parameter int                         N_SLAVES   = 4,
   parameter int                         ADDR_W     = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] BASE       = DEF_BASE,
   parameter logic [N_SLAVES*ADDR_W-1:0] MASK       = DEF_MASK,
   parameter logic [ADDR_W-1:0]          FAULT_BASE = 32'h0000_0FF0,
   localparam int                        IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
   input  logic [ADDR_W-1:0]   addr,
   output logic [N_SLAVES-1:0] hit_onehot,
   output logic [IDX_W-1:0]    hit_idx,
   output logic                fault_hit,
   output logic                unmapped
);

   localparam logic [ADDR_W-1:0] c_FLT_ADDR = FAULT_BASE + ADDR_W'(FLT_ADDR_OFS);
   localparam logic [ADDR_W-1:0] c_FLT_STAT = FAULT_BASE + ADDR_W'(FLT_STAT_OFS);

   logic [N_SLAVES-1:0] w_match;
   logic                w_anyHit;

   for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_match
      assign w_match[gi] = ((addr & MASK[gi*ADDR_W +: ADDR_W]) ==
                            (BASE[gi*ADDR_W +: ADDR_W] & MASK[gi*ADDR_W +: ADDR_W]));
   end

   always_comb begin
      hit_onehot = '0;
      hit_idx    = '0;
      w_anyHit   = 1'b0;
      // Descending scan so the lowest matching index is the one left standing.
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            hit_idx  = IDX_W'(i);
            w_anyHit = 1'b1;
         end
      end
      fault_hit = (addr == c_FLT_ADDR) || (addr == c_FLT_STAT);
      if (w_anyHit && !fault_hit) begin
         hit_onehot[hit_idx] = 1'b1;
      end
      unmapped = !fault_hit && !w_anyHit;
   end

endmodule

`default_nettype wire

// File: rtl/sm_bus_matrix.sv
//==============================================================================
// Module   : sm_bus_matrix
// Brief    : Master-to-N-slave bus matrix with wait states, timeout and fault log.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sm_bus_matrix
   import sm_bus_pkg::*;
#(
   parameter int                         N_SLAVES   = 4,
   parameter int                         DATA_W     = 32,
   parameter int                         ADDR_W     = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_BASE,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_MASK,
   parameter int                         TIMEOUT    = 15,
   parameter logic [ADDR_W-1:0]          FAULT_BASE = 32'h0000_0FF0
) (
   input  logic                       clk,
   input  logic                       rst_p,
   input  logic                       m_req,
   input  logic                       m_we,
   input  logic [ADDR_W-1:0]          m_addr,
   input  logic [DATA_W-1:0]          m_wdata,
   output logic [DATA_W-1:0]          m_rdata,
   output logic                       m_ready,
   output logic                       m_err,
   output logic [N_SLAVES-1:0]        s_sel,
   output logic                       s_we,
   output logic [ADDR_W-1:0]          s_addr,
   output logic [DATA_W-1:0]          s_wdata,
   input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
   input  logic [N_SLAVES-1:0]        s_ready,
   output logic                       fault_irq
);

   localparam int                IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int                CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] c_FLT_STAT = FAULT_BASE + ADDR_W'(FLT_STAT_OFS);

   logic [N_SLAVES-1:0] w_hitOnehot;
   logic [IDX_W-1:0]    w_hitIdx;
   logic                w_faultHit;
   logic                w_unmapped;

   busState_t           r_state,        w_stateNext;
   logic [IDX_W-1:0]    r_idx,          w_idxNext;
   logic [CNT_W-1:0]    r_waitCnt,      w_waitCntNext;
   logic [N_SLAVES-1:0] r_sSel,         w_sSelNext;
   logic                r_sWe,          w_sWeNext;
   logic [ADDR_W-1:0]   r_sAddr,        w_sAddrNext;
   logic [DATA_W-1:0]   r_sWdata,       w_sWdataNext;
   logic                r_mErr,         w_mErrNext;
   logic [DATA_W-1:0]   r_mRdata,       w_mRdataNext;
   logic [ADDR_W-1:0]   r_faultAddr,    w_faultAddrNext;
   logic                r_flagTimeout,  w_flagTimeoutNext;
   logic                r_flagUnmapped, w_flagUnmappedNext;
   logic                r_faultIrq;

   logic                w_selReady;
   logic [DATA_W-1:0]   w_selRdata;

   sm_bus_decoder #(
      .N_SLAVES   (N_SLAVES),
      .ADDR_W     (ADDR_W),
      .BASE       (SLAVE_BASE),
      .MASK       (SLAVE_MASK),
      .FAULT_BASE (FAULT_BASE)
   ) u_decoder (
      .addr       (m_addr),
      .hit_onehot (w_hitOnehot),
      .hit_idx    (w_hitIdx),
      .fault_hit  (w_faultHit),
      .unmapped   (w_unmapped)
   );

   assign w_selReady = s_ready[r_idx];
   assign w_selRdata = s_rdata[r_idx*DATA_W +: DATA_W];

   always_comb begin
      w_stateNext        = r_state;
      w_idxNext          = r_idx;
      w_waitCntNext      = r_waitCnt;
      w_sSelNext         = r_sSel;
      w_sWeNext          = r_sWe;
      w_sAddrNext        = r_sAddr;
      w_sWdataNext       = r_sWdata;
      w_mErrNext         = r_mErr;
      w_mRdataNext       = r_mRdata;
      w_faultAddrNext    = r_faultAddr;
      w_flagTimeoutNext  = r_flagTimeout;
      w_flagUnmappedNext = r_flagUnmapped;

      unique case (r_state)
         IDLE: begin
            if (m_req) begin
               w_sWeNext     = m_we;
               w_sAddrNext   = m_addr;
               w_sWdataNext  = m_wdata;
               w_idxNext     = w_hitIdx;
               w_waitCntNext = '0;
               w_mRdataNext  = '0;
               if (w_faultHit) begin
                  w_stateNext = RESP;
                  w_mErrNext  = 1'b0;
                  if (m_addr == c_FLT_STAT) begin
                     if (m_we) begin
                        w_flagTimeoutNext  = 1'b0;
                        w_flagUnmappedNext = 1'b0;
                     end else begin
                        w_mRdataNext[STAT_TIMEOUT_BIT]  = r_flagTimeout;
                        w_mRdataNext[STAT_UNMAPPED_BIT] = r_flagUnmapped;
                     end
                  end else if (!m_we) begin
                     w_mRdataNext = DATA_W'(r_faultAddr);
                  end
               end else if (w_unmapped) begin
                  w_stateNext        = RESP;
                  w_mErrNext         = 1'b1;
                  w_flagUnmappedNext = 1'b1;
                  w_faultAddrNext    = m_addr;
               end else begin
                  w_stateNext = ACCESS;
                  w_sSelNext  = w_hitOnehot;
               end
            end
         end
         ACCESS: begin
            w_waitCntNext = r_waitCnt + CNT_W'(1);
            if (w_selReady) begin
               w_stateNext  = RESP;
               w_sSelNext   = '0;
               w_mErrNext   = 1'b0;
               w_mRdataNext = w_selRdata;
            end else if (r_waitCnt == CNT_W'(TIMEOUT - 1)) begin
               w_stateNext       = RESP;
               w_sSelNext        = '0;
               w_mErrNext        = 1'b1;
               w_mRdataNext      = '0;
               w_flagTimeoutNext = 1'b1;
               w_faultAddrNext   = r_sAddr;
            end
         end
         RESP: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
            w_sSelNext  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         r_state        <= IDLE;
         r_idx          <= '0;
         r_waitCnt      <= '0;
         r_sSel         <= '0;
         r_sWe          <= 1'b0;
         r_sAddr        <= '0;
         r_sWdata       <= '0;
         r_mErr         <= 1'b0;
         r_mRdata       <= '0;
         r_faultAddr    <= '0;
         r_flagTimeout  <= 1'b0;
         r_flagUnmapped <= 1'b0;
         r_faultIrq     <= 1'b0;
      end else begin
         r_state        <= w_stateNext;
         r_idx          <= w_idxNext;
         r_waitCnt      <= w_waitCntNext;
         r_sSel         <= w_sSelNext;
         r_sWe          <= w_sWeNext;
         r_sAddr        <= w_sAddrNext;
         r_sWdata       <= w_sWdataNext;
         r_mErr         <= w_mErrNext;
         r_mRdata       <= w_mRdataNext;
         r_faultAddr    <= w_faultAddrNext;
         r_flagTimeout  <= w_flagTimeoutNext;
         r_flagUnmapped <= w_flagUnmappedNext;
         // Lags the flags by one cycle so software sees it after the RESP.
         r_faultIrq     <= r_flagTimeout | r_flagUnmapped;
      end
   end

   assign m_ready   = (r_state == RESP);
   assign m_err     = r_mErr;
   assign m_rdata   = r_mRdata;
   assign s_sel     = r_sSel;
   assign s_we      = r_sWe;
   assign s_addr    = r_sAddr;
   assign s_wdata   = r_sWdata;
   assign fault_irq = r_faultIrq;

endmodule

`default_nettype wire

// File: doc/sm_bus_matrix.md
# sm_bus_matrix

Parametrised memory-mapped interconnect between the core's data-memory port and up to N_SLAVES peripherals (RAM, hex display, future I/O), replacing fixed two-way decoding. It decodes each address against per-slave base/mask pairs and runs a registered request/ready handshake with per-slave wait states and a timeout. Unmapped or timed-out accesses return an error and are logged in a built-in fault register window readable by software.

## Interface
Parameters:
- N_SLAVES, 4: number of slave ports (1..8).
- DATA_W, 32: data width.
- ADDR_W, 32: address width.
- SLAVE_BASE, sm_bus_pkg::DEF_BASE: packed N_SLAVES×ADDR_W base addresses. Default slave0 0x000, slave1 0x400, slave2 0x800, slave3 0x900.
- SLAVE_MASK, sm_bus_pkg::DEF_MASK: packed compare masks. Default 0xC00, 0xFF0, 0xF00, 0xF00 (bits 31:12 excluded).
- TIMEOUT, 15: maximum ACCESS cycles before error.
- FAULT_BASE, 32'h0000_0FF0: base of the 2-word fault window.

Ports:
- clk  in  1  clock.
- rst_p  in  1  asynchronous, active-high reset.
- m_req  in  1  master request; held until m_ready.
- m_we  in  1  write enable.
- m_addr  in  ADDR_W  byte address.
- m_wdata  in  DATA_W  write data.
- m_rdata  out  DATA_W  read data, valid while m_ready.
- m_ready  out  1  one-cycle completion strobe.
- m_err  out  1  error qualifier, valid with m_ready.
- s_sel  out  N_SLAVES  one-hot slave select.
- s_we  out  1  registered write enable.
- s_addr  out  ADDR_W  registered address.
- s_wdata  out  DATA_W  registered write data.
- s_rdata  in  N_SLAVES×DATA_W  packed slave read data.
- s_ready  in  N_SLAVES  per-slave ready.
- fault_irq  out  1  OR of sticky fault flags.

## Operation
- Decode: slave i hits when (m_addr & MASK[i]) == (BASE[i] & MASK[i]). The fault window (FAULT_BASE, FAULT_BASE+4) has priority over all slaves. Among slaves, the lowest index wins.
- FSM IDLE → ACCESS → RESP → IDLE:
  - IDLE: on m_req, latch addr/we/wdata and the decoded index.
    - Slave hit → ACCESS.
    - Fault-window or unmapped → RESP directly.
  - ACCESS: s_sel[idx]=1 and wait_cnt increments each cycle.
    - s_ready[idx]=1 → capture s_rdata[idx] → RESP, err=0.
    - wait_cnt==TIMEOUT-1 without ready → RESP, err=1, rdata=0, timeout flag set, fault_addr updated.
  - RESP: m_ready=1 for exactly one cycle, then IDLE. m_req is not sampled during RESP.
- Fault window:
  - Read FAULT_BASE → fault_addr.
  - Read FAULT_BASE+4 → {30'b0, timeout_flag, unmapped_flag}.
  - Write FAULT_BASE+4 → clears both flags.
  - Write FAULT_BASE → ignored.
  - Fault-window accesses never set m_err.
- Unmapped access: m_err=1, rdata=0, unmapped_flag set, fault_addr=m_addr. Writes are dropped; no s_sel asserted.
- Ready from non-selected slaves, and any s_ready outside ACCESS, is ignored.

## Timing
- Reset values: state IDLE, s_sel=0, s_we=0, s_addr=0, s_wdata=0, m_ready=0, m_err=0, m_rdata=0, fault_addr=0, flags=0, fault_irq=0, wait_cnt=0.
- Reset mid-access immediately aborts: s_sel drops asynchronously and no m_ready is issued.
- Latency is measured from the m_req sampling edge (cycle 0):
  - Zero-wait slave: s_sel in cycle 1, m_ready in cycle 2.
  - k-wait slave: m_ready in cycle 2+k.
  - Timeout: m_ready+m_err in cycle 1+TIMEOUT.
  - Fault-window or unmapped access: m_ready in cycle 1.
- Back-to-back: the next request is sampled in the cycle after RESP, so minimum throughput is one access per 3 cycles.
- s_addr, s_wdata and s_we are stable for the whole ACCESS state.
- fault_irq is registered and follows the flag state one cycle after the setting or clearing RESP.

## Structure
- Package sm_bus_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - DEF_BASE and DEF_MASK;
  - fault offsets FLT_ADDR_OFS=0 and FLT_STAT_OFS=4;
  - status bit positions.
- Sub-module sm_bus_decoder: combinational, parametrised by N_SLAVES, BASE, MASK and FAULT_BASE. Outputs hit_onehot, hit_idx, fault_hit and unmapped.
- wait_cnt width is $clog2(TIMEOUT+1).

## Test plan
- Zero-wait RAM: write 0xDEADBEEF to 0x010, then read 0x010. Both give m_ready at cycle 2, m_err=0, and the read returns 0xDEADBEEF with s_sel=4'b0001 for exactly one cycle.
- Hex slave with 3 wait states: read 0x404 → s_sel=4'b0010 for 4 cycles, m_ready at cycle 5 with slave data, m_err=0.
- Timeout: slave2 never ready, read 0x820 → m_ready at cycle 16 with m_err=1 and m_rdata=0. Then fault window reads give 0x820 and status 0x2, and fault_irq=1.
- Unmapped: write to 0xA00 → m_ready at cycle 1 with m_err=1, s_sel stays 0 and status reads 0x1. Writing FAULT_BASE+4 clears the status, and fault_irq falls one cycle later.
- Overlap priority: set MASK so slaves 2 and 3 both match 0x900 → slave 2 is selected. A read of 0xFF4 hits the fault window rather than any slave.
- Reset mid-access: assert rst_p in cycle 2 of a 5-wait access → s_sel=0 immediately, no m_ready; the next request after deassertion completes normally.
